// File: rtl/mmio_mailbox.sv
// Memory-mapped TX/RX mailbox on the core load/store bus: stores to TX_DATA feed a valid/ready
// consumer, loads from RX_DATA drain a valid/ready producer, with STATUS and CTRL registers alongside.
module mmio_mailbox #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [2:0]  funct3,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        hit,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);
    localparam int            CW       = $clog2(DEPTH) + 1;
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   txMem_r [DEPTH];
    logic [31:0]   rxMem_r [DEPTH];
    logic [PW-1:0] txWr_r, txRd_r, rxWr_r, rxRd_r;
    logic [CW-1:0] txCnt_r, rxCnt_r;
    logic          ovf_r, unf_r, ie_r;

    logic          inWindow_s, loadLegal_s, storeLegal_s;
    logic [1:0]    regOff_s;
    logic [31:0]   selReg_s, shifted_s, loadWord_s, pushWord_s, status_s, rxHead_s;
    logic          txPush_s, txPushOk_s, txPopOk_s;
    logic          rxPopReq_s, rxPopOk_s, rxPushOk_s;
    logic          ctrlWrite_s, flush_s;

    assign inWindow_s = (address[31:4] == BASE_ADDR[31:4]);
    assign regOff_s   = address[3:2];
    assign hit        = (MemRead | MemWrite) & inWindow_s;

    assign rxHead_s = (rxCnt_r != {CW{1'b0}}) ? rxMem_r[rxRd_r] : 32'h0000_0000;
    assign status_s = {8'h00, {(8-CW){1'b0}}, txCnt_r, {(8-CW){1'b0}}, rxCnt_r, 2'b00,
                       unf_r, ovf_r, (txCnt_r == FULL_CNT), (txCnt_r == {CW{1'b0}}),
                       (rxCnt_r == FULL_CNT), (rxCnt_r == {CW{1'b0}})};

    // Load path: register select, byte-lane shift, then width/sign extension
    always_comb begin
        selReg_s = 32'h0000_0000;
        case (regOff_s)
            2'd0:    selReg_s = 32'h0000_0000;
            2'd1:    selReg_s = rxHead_s;
            2'd2:    selReg_s = status_s;
            2'd3:    selReg_s = {31'h0000_0000, ie_r};
            default: selReg_s = 32'h0000_0000;
        endcase
        shifted_s   = selReg_s >> {address[1:0], 3'b000};
        loadLegal_s = 1'b1;
        loadWord_s  = 32'h0000_0000;
        case (funct3)
            3'b000:  loadWord_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
            3'b001:  loadWord_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
            3'b010:  loadWord_s = shifted_s;
            3'b100:  loadWord_s = {24'h00_0000, shifted_s[7:0]};
            3'b101:  loadWord_s = {16'h0000, shifted_s[15:0]};
            default: loadLegal_s = 1'b0;
        endcase
    end

    assign readData = (MemRead & inWindow_s & loadLegal_s) ? loadWord_s : 32'h0000_0000;

    // Store width selection for TX pushes; the byte lane is always the low end of writeData
    always_comb begin
        storeLegal_s = 1'b1;
        pushWord_s   = 32'h0000_0000;
        case (funct3)
            3'b000:  pushWord_s = {24'h00_0000, writeData[7:0]};
            3'b001:  pushWord_s = {16'h0000, writeData[15:0]};
            3'b010:  pushWord_s = writeData;
            default: storeLegal_s = 1'b0;
        endcase
    end

    assign txPush_s    = MemWrite & inWindow_s & (regOff_s == 2'd0) & storeLegal_s;
    assign txPushOk_s  = txPush_s & (txCnt_r != FULL_CNT);
    assign txPopOk_s   = tx_ready & (txCnt_r != {CW{1'b0}});
    assign rxPopReq_s  = MemRead & inWindow_s & (regOff_s == 2'd1) & loadLegal_s;
    assign rxPopOk_s   = rxPopReq_s & (rxCnt_r != {CW{1'b0}});
    assign rxPushOk_s  = rx_valid & (rxCnt_r != FULL_CNT);
    assign ctrlWrite_s = MemWrite & inWindow_s & (regOff_s == 2'd3);
    assign flush_s     = ctrlWrite_s & writeData[2];

    // FIFO storage; contents are only meaningful between the read and write pointers
    always_ff @(posedge clk) begin
        if (txPushOk_s) begin
            txMem_r[txWr_r] <= pushWord_s;
        end
        if (rxPushOk_s) begin
            rxMem_r[rxWr_r] <= rx_data;
        end
    end

    // Pointers, counts and flags; a flush wins over the handshake beats of the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            txWr_r  <= {PW{1'b0}};
            txRd_r  <= {PW{1'b0}};
            rxWr_r  <= {PW{1'b0}};
            rxRd_r  <= {PW{1'b0}};
            txCnt_r <= {CW{1'b0}};
            rxCnt_r <= {CW{1'b0}};
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            ie_r    <= 1'b0;
        end else begin
            if (txPushOk_s) txWr_r <= txWr_r + 1'b1;
            if (txPopOk_s)  txRd_r <= txRd_r + 1'b1;
            if (rxPushOk_s) rxWr_r <= rxWr_r + 1'b1;
            if (rxPopOk_s)  rxRd_r <= rxRd_r + 1'b1;
            txCnt_r <= txCnt_r + CW'(txPushOk_s) - CW'(txPopOk_s);
            rxCnt_r <= rxCnt_r + CW'(rxPushOk_s) - CW'(rxPopOk_s);
            if (txPush_s & ~txPushOk_s)  ovf_r <= 1'b1;
            if (rxPopReq_s & ~rxPopOk_s) unf_r <= 1'b1;
            if (ctrlWrite_s) begin
                ie_r <= writeData[0];
                if (writeData[1]) begin
                    ovf_r <= 1'b0;
                    unf_r <= 1'b0;
                end
            end
            if (flush_s) begin
                txWr_r  <= {PW{1'b0}};
                txRd_r  <= {PW{1'b0}};
                rxWr_r  <= {PW{1'b0}};
                rxRd_r  <= {PW{1'b0}};
                txCnt_r <= {CW{1'b0}};
                rxCnt_r <= {CW{1'b0}};
            end
        end
    end

    assign tx_valid = ~rst & (txCnt_r != {CW{1'b0}});
    assign tx_data  = tx_valid ? txMem_r[txRd_r] : 32'h0000_0000;
    assign rx_ready = ~rst & (rxCnt_r != FULL_CNT);
    assign irq      = ~rst & ie_r & (rxCnt_r != {CW{1'b0}});
endmodule

// File: tb/tb_mmio_mailbox.sv
// Bench for mmio_mailbox: directed scenarios then random bus/handshake traffic, all checked
// against a queue-based model of the mailbox.
module tb_mmio_mailbox;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, writeData, readData, tx_data, rx_data;
    logic [2:0]  funct3;
    logic        MemWrite, MemRead, hit, tx_valid, tx_ready, rx_valid, rx_ready, irq;

    int passed = 0;
    int total  = 0;

    logic [31:0] txQ[$];
    logic [31:0] rxQ[$];
    logic        mOvf, mUnf, mIe;

    always #5 clk = ~clk;

    mmio_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .address(address), .funct3(funct3), .MemWrite(MemWrite),
        .MemRead(MemRead), .writeData(writeData), .readData(readData), .hit(hit),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic inWin();
        return address[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] mStatus();
        logic [31:0] s = 32'h0;
        s[0]     = (rxQ.size() == 0);
        s[1]     = (rxQ.size() == DEPTH);
        s[2]     = (txQ.size() == 0);
        s[3]     = (txQ.size() == DEPTH);
        s[4]     = mOvf;
        s[5]     = mUnf;
        s[15:8]  = 8'(rxQ.size());
        s[23:16] = 8'(txQ.size());
        return s;
    endfunction

    function automatic logic legalLoad();
        return funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic logic [31:0] mRead();
        logic [31:0] r = 32'h0;
        logic [31:0] w;
        if (!MemRead || !inWin() || !legalLoad()) return 32'h0;
        case (address[3:2])
            2'd1:    r = (rxQ.size() > 0) ? rxQ[0] : 32'h0;
            2'd2:    r = mStatus();
            2'd3:    r = {31'h0, mIe};
            default: r = 32'h0;
        endcase
        w = r >> (8 * int'(address[1:0]));
        case (funct3)
            3'd0:    return 32'($signed(w[7:0]));
            3'd1:    return 32'($signed(w[15:0]));
            3'd4:    return w & 32'h0000_00FF;
            3'd5:    return w & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    task automatic mUpdate();
        logic        pend;
        logic [31:0] d;
        logic        rxRoom;
        if (rst) begin
            txQ.delete(); rxQ.delete();
            mOvf = 1'b0; mUnf = 1'b0; mIe = 1'b0;
            return;
        end
        rxRoom = (rxQ.size() < DEPTH);
        pend   = 1'b0;
        d      = 32'h0;
        if (MemWrite && inWin() && address[3:2] == 2'd0 && funct3 inside {3'd0, 3'd1, 3'd2}) begin
            d = (funct3 == 3'd0) ? (writeData & 32'hFF) :
                (funct3 == 3'd1) ? (writeData & 32'hFFFF) : writeData;
            if (txQ.size() < DEPTH) pend = 1'b1;
            else mOvf = 1'b1;
        end
        if (tx_ready && txQ.size() > 0) void'(txQ.pop_front());
        if (pend) txQ.push_back(d);
        if (MemRead && inWin() && address[3:2] == 2'd1 && legalLoad()) begin
            if (rxQ.size() == 0) mUnf = 1'b1;
            else void'(rxQ.pop_front());
        end
        if (rx_valid && rxRoom) rxQ.push_back(rx_data);
        if (MemWrite && inWin() && address[3:2] == 2'd3) begin
            mIe = writeData[0];
            if (writeData[1]) begin mOvf = 1'b0; mUnf = 1'b0; end
            if (writeData[2]) begin txQ.delete(); rxQ.delete(); end
        end
    endtask

    // One clock: check decode outputs, advance model, check registered outputs after the edge
    task automatic cycle();
        logic live;
        #2;
        chk("hit", {31'h0, hit}, {31'h0, (MemRead | MemWrite) & inWin()});
        chk("readData", readData, mRead());
        mUpdate();
        @(posedge clk);
        #1;
        live = !rst;
        chk("tx_valid", {31'h0, tx_valid}, {31'h0, live && txQ.size() > 0});
        chk("tx_data", tx_data, (live && txQ.size() > 0) ? txQ[0] : 32'h0);
        chk("rx_ready", {31'h0, rx_ready}, {31'h0, live && rxQ.size() < DEPTH});
        chk("irq", {31'h0, irq}, {31'h0, live && mIe && rxQ.size() > 0});
    endtask

    task automatic bus(input logic [31:0] a, input logic [2:0] f, input logic we, input logic re,
                       input logic [31:0] wd);
        address = a; funct3 = f; MemWrite = we; MemRead = re; writeData = wd;
    endtask

    task automatic idle();
        bus(32'h0, 3'd0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic peekStatus(output logic [31:0] s);
        bus(BASE + 32'd8, 3'd2, 1'b0, 1'b1, 32'h0);
        #2;
        s = readData;
        #0;
    endtask

    initial begin
        logic [31:0] st;
        logic [31:0] a;
        logic [2:0]  f;
        int          op;
        txQ.delete(); rxQ.delete();
        mOvf = 1'b0; mUnf = 1'b0; mIe = 1'b0;
        rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 32'h0;
        idle();
        cycle();
        cycle();
        rst = 1'b0;
        idle();
        cycle();

        // T1: single word store visible next cycle
        bus(BASE, 3'd2, 1'b1, 1'b0, 32'hDEAD_BEEF);
        cycle();
        chk("T1 tx_data", tx_data, 32'hDEAD_BEEF);
        chk("T1 tx_valid", {31'h0, tx_valid}, 32'h1);
        peekStatus(st);
        chk("T1 tx_cnt", (st >> 16) & 32'hFF, 32'h1);
        cycle();
        idle(); tx_ready = 1'b1;
        cycle();
        tx_ready = 1'b0;

        // T2: overfill TX then drain in order
        for (int i = 0; i < 9; i++) begin
            bus(BASE, 3'd2, 1'b1, 1'b0, 32'h100 + 32'(i));
            cycle();
        end
        peekStatus(st);
        chk("T2 tx_full", (st >> 3) & 32'h1, 32'h1);
        chk("T2 ovf", (st >> 4) & 32'h1, 32'h1);
        cycle();
        idle(); tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("T2 drain", tx_data, 32'h100 + 32'(i));
            cycle();
        end
        chk("T2 empty", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // T3: signed and unsigned byte loads from RX
        rx_valid = 1'b1; rx_data = 32'h0000_00F0;
        cycle();
        rx_valid = 1'b0;
        bus(BASE + 32'd4, 3'd0, 1'b0, 1'b1, 32'h0);
        #2;
        chk("T3 lb", readData, 32'hFFFF_FFF0);
        cycle();
        peekStatus(st);
        chk("T3 rx_empty", st & 32'h1, 32'h1);
        cycle();
        rx_valid = 1'b1; idle();
        cycle();
        rx_valid = 1'b0;
        bus(BASE + 32'd4, 3'd4, 1'b0, 1'b1, 32'h0);
        #2;
        chk("T3 lbu", readData, 32'h0000_00F0);
        cycle();

        // T4: underflow, then clear flags through CTRL
        bus(BASE + 32'd4, 3'd2, 1'b0, 1'b1, 32'h0);
        #2;
        chk("T4 lw empty", readData, 32'h0);
        cycle();
        peekStatus(st);
        chk("T4 unf", (st >> 5) & 32'h1, 32'h1);
        cycle();
        bus(BASE + 32'd12, 3'd2, 1'b1, 1'b0, 32'h2);
        cycle();
        peekStatus(st);
        chk("T4 flags clear", (st >> 4) & 32'h3, 32'h0);
        cycle();

        // T5: full RX, pop and offered beat in the same cycle
        idle(); rx_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rx_data = 32'h200 + 32'(i);
            cycle();
        end
        rx_data = 32'h2FF;
        bus(BASE + 32'd4, 3'd2, 1'b0, 1'b1, 32'h0);
        #2;
        chk("T5 rx_ready full", {31'h0, rx_ready}, 32'h0);
        chk("T5 pop head", readData, 32'h200);
        cycle();
        peekStatus(st);
        chk("T5 rx_cnt", (st >> 8) & 32'hFF, 32'(DEPTH - 1));
        cycle();
        rx_valid = 1'b0;
        peekStatus(st);
        chk("T5 refill", (st >> 8) & 32'hFF, 32'(DEPTH));
        cycle();

        // T6: interrupt, flush, then reset mid-stream
        bus(BASE + 32'd12, 3'd2, 1'b1, 1'b0, 32'h1);
        cycle();
        chk("T6 irq", {31'h0, irq}, 32'h1);
        bus(BASE, 3'd2, 1'b1, 1'b0, 32'h55);
        cycle();
        bus(BASE + 32'd12, 3'd2, 1'b1, 1'b0, 32'h5);
        cycle();
        chk("T6 irq off", {31'h0, irq}, 32'h0);
        chk("T6 tx empty", {31'h0, tx_valid}, 32'h0);
        bus(BASE + 32'd12, 3'd2, 1'b0, 1'b1, 32'h0);
        #2;
        chk("T6 ie kept", readData, 32'h1);
        cycle();
        rx_valid = 1'b1; rx_data = 32'h77;
        bus(BASE, 3'd2, 1'b1, 1'b0, 32'h66);
        cycle();
        rst = 1'b1; idle();
        cycle();
        chk("T6 rst rx_ready", {31'h0, rx_ready}, 32'h0);
        rst = 1'b0; rx_valid = 1'b0;
        cycle();
        chk("T6 rst tx_valid", {31'h0, tx_valid}, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            op = int'($urandom_range(0, 9));
            tx_ready = $urandom_range(0, 2) != 0;
            rx_valid = $urandom_range(0, 1) != 0;
            rx_data  = $urandom;
            a = BASE | ($urandom & 32'h3);
            f = 3'($urandom_range(0, 7));
            case (op)
                0, 1, 2: bus(a, 3'($urandom_range(0, 2)), 1'b1, 1'b0, $urandom);
                3, 4:    bus(a + 32'd4, f, 1'b0, 1'b1, 32'h0);
                5:       bus(a + 32'd8, f, 1'b0, 1'b1, 32'h0);
                6:       bus(BASE | ($urandom & 32'hF), f, $urandom_range(0, 1) == 0, 1'b0, $urandom);
                7:       bus(BASE + 32'd12, 3'd2, 1'b1, 1'b0,
                             ($urandom & 32'h3) | (($urandom_range(0, 7) == 0) ? 32'h4 : 32'h0));
                8:       bus($urandom & 32'h0000_0FFF, f, $urandom_range(0, 1) == 0, 1'b1, $urandom);
                default: idle();
            endcase
            if (op == 6 && !MemWrite) MemRead = 1'b1;
            if (op == 8 && MemWrite) MemRead = 1'b0;
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
